// File: rtl/blit_pkg.sv
// blit_pkg: shared field widths, packed-entry layout and sequencer state encoding for the blit scheduler
// Contents: BLIT_*_W widths, *_LSB offsets of {op, src, height, destX, destY}, state_t, pack_cmd()
package blit_pkg;
  localparam int BLIT_OP_W  = 3;
  localparam int BLIT_SRC_W = 12;
  localparam int BLIT_H_W   = 4;
  localparam int BLIT_X_W   = 7;
  localparam int BLIT_Y_W   = 6;
  localparam int BLIT_CMD_W = 32;
  localparam int Y_LSB   = 0;
  localparam int X_LSB   = Y_LSB + BLIT_Y_W;
  localparam int H_LSB   = X_LSB + BLIT_X_W;
  localparam int SRC_LSB = H_LSB + BLIT_H_W;
  localparam int OP_LSB  = SRC_LSB + BLIT_SRC_W;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_COMPLETE} state_t;
  function automatic logic [BLIT_CMD_W-1:0] pack_cmd(
    input logic [BLIT_OP_W-1:0]  op,
    input logic [BLIT_SRC_W-1:0] src,
    input logic [BLIT_H_W-1:0]   h,
    input logic [BLIT_X_W-1:0]   x,
    input logic [BLIT_Y_W-1:0]   y
  );
    return {op, src, h, x, y};
  endfunction
endpackage

// File: rtl/blit_cmd_fifo.sv
// blit_cmd_fifo: synchronous FIFO of packed blit commands exposing the oldest entry as head
// Ports: clk/res clock and sync reset; push+wdata enqueue; pop dequeue; head = oldest entry; full/empty status
module blit_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         res,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  // extra pointer MSB distinguishes a full ring from an empty one
  assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign head = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= wdata;
  always_ff @(posedge clk) begin
    if (res) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/blit_scheduler.sv
// blit_scheduler: queues CPU blit commands and issues them one at a time to the blitter, reporting completion and collisions
// Ports: clk/res clock and sync reset; req_* CPU command handshake; vblank issue gate; blit_* blitter command and
// enable/ready handshake; done/done_collision per-command result; collision_sticky/collision_clr; busy; overflow
module blit_scheduler
  import blit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter bit VSYNC_GATE = 1'b0,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        res,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [11:0] req_src,
  input  logic [3:0]  req_height,
  input  logic [6:0]  req_destX,
  input  logic [5:0]  req_destY,
  input  logic        vblank,
  output logic [2:0]  blit_op,
  output logic [11:0] blit_src,
  output logic [3:0]  blit_srcHeight,
  output logic [6:0]  blit_destX,
  output logic [5:0]  blit_destY,
  output logic        blit_enable,
  input  logic        blit_ready,
  input  logic        blit_collision,
  output logic        done,
  output logic        done_collision,
  output logic        collision_sticky,
  input  logic        collision_clr,
  output logic        busy,
  output logic        overflow
);
  // the enable cycle counts toward the timeout, so an instant op completes BUSY_TIMEOUT cycles after enable
  localparam logic [3:0] TO_LAST = 4'(BUSY_TIMEOUT - 2);
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic full, empty, push, start;
  logic [BLIT_CMD_W-1:0] head;
  assign push = req_valid && !full;
  assign req_ready = !full;
  assign start = state == S_IDLE && !empty && blit_ready && (!VSYNC_GATE || vblank);
  blit_cmd_fifo #(.DEPTH(DEPTH), .W(BLIT_CMD_W)) u_fifo (
    .clk   (clk),
    .res   (res),
    .push  (push),
    .wdata (pack_cmd(req_op, req_src, req_height, req_destX, req_destY)),
    .pop   (start),
    .head  (head),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk) state <= res ? S_IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      state_nxt = start ? S_ISSUE : S_IDLE;
      S_ISSUE:     state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: state_nxt = !blit_ready ? S_WAIT_DONE : cnt == TO_LAST ? S_COMPLETE : S_WAIT_BUSY;
      S_WAIT_DONE: state_nxt = blit_ready ? S_COMPLETE : S_WAIT_DONE;
      S_COMPLETE:  state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end
  always_comb begin
    blit_enable = state == S_ISSUE;
    done = state == S_COMPLETE;
    done_collision = done && blit_collision;
    busy = push || !empty || state != S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (res) begin
      {blit_op, blit_src, blit_srcHeight, blit_destX, blit_destY} <= '0;
      cnt <= '0;
      collision_sticky <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (start) {blit_op, blit_src, blit_srcHeight, blit_destX, blit_destY} <= head;
      cnt <= state == S_ISSUE ? 4'd0 : state == S_WAIT_BUSY ? cnt + 1'b1 : cnt;
      // a completing collision beats a simultaneous clear
      collision_sticky <= (done && blit_collision) || (collision_sticky && !collision_clr);
      overflow <= overflow || (req_valid && full);
    end
  end
endmodule
